// File: rtl/mult_pkg.sv
// Shared widths and vector types for the multiplier's carry-save resolve path.
// The high field covers product bits 31:7; the low field arrives already resolved.
package mult_pkg;
  localparam int LOW_W  = 7;
  localparam int HIGH_W = 25;
  localparam int SPLIT  = 13;
  localparam int PROD_W = LOW_W + HIGH_W;

  typedef logic [HIGH_W-1:0] sc_vec_t;
  typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/csa_pipe_reg.sv
// One valid/ready pipeline register: loads when empty or when drained in the same cycle.
// Ready is combinational from out_ready (no bubble) and held low during reset.
module csa_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      // Data only moves on a real load so idle registers stay quiet.
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/csa_resolve_pipe.sv
// Resolves a carry-save sum/carry pair into a binary product over two pipeline stages.
// Stage 1 adds the low SPLIT bits, stage 2 adds the rest plus the stage-1 carry.
module csa_resolve_pipe #(
  parameter int LOW_W  = mult_pkg::LOW_W,
  parameter int HIGH_W = mult_pkg::HIGH_W,
  parameter int SPLIT  = mult_pkg::SPLIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HIGH_W-1:0]       in_sum,
  input  logic [HIGH_W-1:0]       in_carry,
  input  logic [LOW_W-1:0]        in_low,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LOW_W+HIGH_W-1:0] out_product
);
  localparam int HI_W   = HIGH_W - SPLIT;
  localparam int S1_W   = SPLIT + 1 + 2 * HI_W + LOW_W;
  localparam int PROD_W = LOW_W + HIGH_W;

  logic [SPLIT:0]    lo_add;
  logic [S1_W-1:0]   s1_in_data;
  logic [S1_W-1:0]   s1_data;
  logic              s1_valid;
  logic              s2_ready;

  logic [SPLIT-1:0]  s1_lo_sum;
  logic              s1_cout;
  logic [HI_W-1:0]   s1_sum_hi;
  logic [HI_W-1:0]   s1_carry_hi;
  logic [LOW_W-1:0]  s1_low;
  logic [HI_W-1:0]   hi_add;
  logic [PROD_W-1:0] s2_in_data;

  assign lo_add = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
  assign s1_in_data = {lo_add[SPLIT-1:0], lo_add[SPLIT],
                       in_sum[HIGH_W-1:SPLIT], in_carry[HIGH_W-1:SPLIT], in_low};

  csa_pipe_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign {s1_lo_sum, s1_cout, s1_sum_hi, s1_carry_hi, s1_low} = s1_data;

  // Truncating to HI_W drops the MSB carry, giving the high field mod 2^HIGH_W.
  assign hi_add     = s1_sum_hi + s1_carry_hi + HI_W'(s1_cout);
  assign s2_in_data = {hi_add, s1_lo_sum, s1_low};

  csa_pipe_reg #(.W(PROD_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_product)
  );
endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Bench for csa_resolve_pipe: directed vector table, backpressure and reset sequences,
// then random streaming against a queue-based reference model.
module tb_csa_resolve_pipe;
  import mult_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid;
  logic     in_ready;
  sc_vec_t  in_sum;
  sc_vec_t  in_carry;
  logic [LOW_W-1:0] in_low;
  logic     out_valid;
  logic     out_ready;
  product_t out_product;

  csa_resolve_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .in_low      (in_low),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] sum;
    logic [24:0] carry;
    logic [6:0]  low;
    logic [31:0] exp;
  } vec_t;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int npush = 0;
  int npop = 0;
  int ndrop = 0;
  logic [31:0] mq[$];
  int          tq[$];
  logic [31:0] last_pop;
  logic        accepted;
  logic        popped;

  function automatic logic [31:0] ref_prod(logic [24:0] s, logic [24:0] c, logic [6:0] l);
    longint t;
    t = (longint'(s) + longint'(c)) % (longint'(1) << 25);
    return 32'(t * 128 + longint'(l));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: check outputs against the model, clock, then advance the model.
  task automatic step();
    logic er, eov, acc, pop;
    #1;
    er  = !rst && (mq.size() < 2 || out_ready);
    eov = (mq.size() > 0) && (cyc - tq[0] >= 1);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(eov));
    if (eov) chk("out_product", out_product, mq[0]);
    acc = in_valid && er;
    pop = eov && out_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      ndrop += mq.size();
      mq.delete();
      tq.delete();
    end else begin
      if (pop) begin
        last_pop = mq.pop_front();
        void'(tq.pop_front());
        npop++;
      end
      if (acc) begin
        mq.push_back(ref_prod(in_sum, in_carry, in_low));
        tq.push_back(cyc);
        npush++;
      end
    end
    accepted = acc;
    popped   = pop;
    #1;
  endtask

  task automatic drive(logic v, logic [24:0] s, logic [24:0] c, logic [6:0] l);
    in_valid = v;
    in_sum   = s;
    in_carry = c;
    in_low   = l;
  endtask

  vec_t vt[5];

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);

    vt[0] = '{25'h1FFFFFF, 25'h0000001, 7'h01, 32'h00000001};
    vt[1] = '{25'h0001FFF, 25'h0000001, 7'h00, 32'h00100000};
    vt[2] = '{25'h1FFFC00, 25'h0000000, 7'h01, 32'hFFFE0001};
    vt[3] = '{25'h0000000, 25'h0000000, 7'h7F, 32'h0000007F};
    vt[4] = '{25'h1000000, 25'h1000000, 7'h55, 32'h00000055};

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_product", out_product, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, each through an empty pipe to observe latency
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vt[i].sum, vt[i].carry, vt[i].low);
      step();
      chk("vec_accept", 32'(accepted), 32'd1);
      drive(1'b0, '0, '0, '0);
      step();
      chk("vec_lat1_no_pop", 32'(popped), 32'd0);
      step();
      chk("vec_lat2_pop", 32'(popped), 32'd1);
      chk("vec_product", last_pop, vt[i].exp);
    end

    // Backpressure: three back-to-back items with the output stalled
    out_ready = 1'b0;
    drive(1'b1, 25'h0000101, 25'h0000001, 7'h11);
    step();
    chk("bp_acc1", 32'(accepted), 32'd1);
    drive(1'b1, 25'h0000202, 25'h0000002, 7'h22);
    step();
    chk("bp_acc2", 32'(accepted), 32'd1);
    drive(1'b1, 25'h0000303, 25'h0000003, 7'h33);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_refused", 32'(accepted), 32'd0);
      chk("bp_hold_item1", out_product, ref_prod(25'h0000101, 25'h0000001, 7'h11));
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_pop1", 32'(popped), 32'd1);
    chk("bp_rel_item1", last_pop, ref_prod(25'h0000101, 25'h0000001, 7'h11));
    chk("bp_acc3", 32'(accepted), 32'd1);
    drive(1'b0, '0, '0, '0);
    step();
    chk("bp_rel_pop2", 32'(popped), 32'd1);
    chk("bp_rel_item2", last_pop, ref_prod(25'h0000202, 25'h0000002, 7'h22));
    step();
    chk("bp_rel_pop3", 32'(popped), 32'd1);
    chk("bp_rel_item3", last_pop, ref_prod(25'h0000303, 25'h0000003, 7'h33));

    // Reset with two items in flight
    drive(1'b1, 25'h0ABCDEF, 25'h0123456, 7'h0A);
    step();
    drive(1'b1, 25'h1111111, 25'h0222222, 7'h0B);
    step();
    drive(1'b0, '0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_product", out_product, 32'd0);
    drive(1'b1, 25'h0000777, 25'h0000111, 7'h3C);
    step();
    chk("mid_rst_accept", 32'(accepted), 32'd1);
    drive(1'b0, '0, '0, '0);
    step();
    chk("mid_rst_lat1", 32'(popped), 32'd0);
    step();
    chk("mid_rst_lat2", 32'(popped), 32'd1);
    chk("mid_rst_item", last_pop, ref_prod(25'h0000777, 25'h0000111, 7'h3C));
    repeat (3) step();

    // Random streaming with random backpressure
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) < 7), 25'($urandom), 25'($urandom), 7'($urandom));
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && mq.size() > 0; i++) step();
    chk("drain_empty", 32'(mq.size()), 32'd0);
    chk("no_loss", 32'(npush), 32'(npop + ndrop));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/csa_resolve_pipe.md
CSA_RESOLVE_PIPE -- requirements
Module: csa_resolve_pipe

Interface
REQ-001 Parameter LOW_W, default 7: width of the already-resolved low product field.
REQ-002 Parameter HIGH_W, default 25: width of the sum and carry vectors, covering product bits 31:7.
REQ-003 Parameter SPLIT, default 13: number of high-field LSBs resolved in stage 1; the remaining HIGH_W-SPLIT bits are resolved in stage 2.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream tree output is valid.
REQ-007 in_ready  output  1  block accepts the input this cycle.
REQ-008 in_sum  input  HIGH_W  carry-save sum vector, product bits 31:7.
REQ-009 in_carry  input  HIGH_W  carry-save carry vector, aligned to in_sum.
REQ-010 in_low  input  LOW_W  resolved product bits 6:0.
REQ-011 out_valid  output  1  out_product is valid.
REQ-012 out_ready  input  1  downstream accepts out_product.
REQ-013 out_product  output  LOW_W+HIGH_W  resolved product {in_sum+in_carry, in_low}.

Function
REQ-014 The block shall accept a transfer on each clk edge where in_valid && in_ready.
REQ-015 Stage 1 shall register in_sum[SPLIT-1:0]+in_carry[SPLIT-1:0] (SPLIT bits), the carry-out of that addition, the untouched upper bits of in_sum and in_carry, and in_low.
REQ-016 Stage 2 shall register the upper sum as in_sum[HIGH_W-1:SPLIT]+in_carry[HIGH_W-1:SPLIT]+stage-1 carry, truncated to HIGH_W-SPLIT bits.
REQ-017 The carry-out of the MSB shall be discarded, so the high field is computed modulo 2^HIGH_W.
REQ-018 out_product shall equal {stage-2 upper sum, stage-1 lower sum, in_low}.
REQ-019 Latency: out_valid shall rise 2 cycles after acceptance when the pipe was empty and out_ready was held high.
REQ-020 Throughput shall be one transfer per cycle while out_ready is high.
REQ-021 Each stage shall load when it is empty or when its contents are consumed in the same cycle.
REQ-022 in_ready shall equal !s1_valid || (s2 load condition); it shall be combinational from out_ready, with no registered bubble.
REQ-023 While out_valid && !out_ready, out_product and out_valid shall hold stable.
REQ-024 Buffer capacity shall be 2 entries; with out_ready low, in_ready shall deassert once both stages are full.
REQ-025 Accept and consume in the same cycle on a full pipe shall shift without loss or duplication.
REQ-026 Order shall be strictly FIFO, with no reordering.
REQ-027 Stage data registers shall load only on a stage load, so the power-idle contents are unchanged.

Reset
REQ-028 While rst is high at a clk edge, s1_valid, s2_valid and out_valid shall clear to 0.
REQ-029 While rst is high at a clk edge, all data registers shall clear to 0, so out_product resets to 0.
REQ-030 in_ready shall be 0 during reset and 1 in the first cycle after rst falls.
REQ-031 Reset mid-operation shall discard every in-flight entry, and no stale entry shall appear afterwards.

Structure
REQ-032 A shared package mult_pkg shall hold LOW_W, HIGH_W, SPLIT, the product width, and the typedefs for the sum/carry vector and the product.
REQ-033 One sub-module, csa_pipe_reg, shall be used: a valid/ready pipeline register with a data-width parameter, instantiated once per stage.
REQ-034 Upstream, in_sum, in_carry and in_low shall connect directly to the Wallace tree's sum, carry and low outputs.

Verification
REQ-035 Single transfer: in_sum=0x1FFFFFF, in_carry=0x0000001, in_low=0x01, out_ready=1 -> out_product=0x00000001 two cycles later (wrap case).
REQ-036 Split-boundary carry: in_sum=0x0001FFF, in_carry=0x0000001, in_low=0x00 -> out_product=0x00100000 (carry crosses stage 1 into stage 2).
REQ-037 Full-scale: the sum/carry pair for 0xFFFF*0xFFFF (sum=0x1FFFC00, carry=0x0000000, low=0x01) -> out_product=0xFFFE0001.
REQ-038 Backpressure: out_ready=0, 3 back-to-back in_valid -> 2 accepted, then in_ready=0; the output holds item 1; on release, items 1,2,3 appear on consecutive cycles.
REQ-039 Reset mid-flight: 2 items in flight, rst pulsed 1 cycle -> out_valid=0 and out_product=0, the next item appears at latency 2, and the old items never appear.
REQ-040 Random streaming with random out_ready -> a scoreboard shall match (sum+carry mod 2^25)<<7 | low for every item, with zero loss.
